topk_acc_32: RTL and testbench
==============================

Name: topk_acc_32

Overview:
- Streaming top-K accumulator directly downstream of the 32-input bitonic backend.
- Consumes a frame of one or more descending-sorted 32-element blocks, one block at a time.
- Keeps a running sorted top-K buffer by merging each block into it with a sequential two-pointer merge.
- On the last block of a frame, presents the frame's top-K values and holds them until accepted.

Parameters:
- DATAWIDTH, 8, element width in bits, unsigned.
- DATALENGTH, 32, elements per input block.
- K, 16, result size; legal range 1..DATALENGTH.
- IDXWIDTH, 16, index width; used only with TOPK_IDX_EN.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- valid_i  in  1  input block valid
- ready_o  out  1  block can be accepted
- last_i  in  1  accepted block is the last of the frame
- x_i  in  DATAWIDTH x DATALENGTH  sorted block, x_i[0] largest, non-increasing
- out_valid_o  out  1  result valid
- out_ready_i  in  1  result consumer ready
- y_o  out  DATAWIDTH x K  result, y_o[0] largest, non-increasing
- idx_o  out  IDXWIDTH x K  source index per result element (TOPK_IDX_EN only)

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_i is asynchronous and active-high.
- Reset values:
  - state IDLE.
  - buf[0..K-1] = 0; idx buffer = 0.
  - ready_o = 1, out_valid_o = 0, y_o = 0.
  - pointers, last flag and block counter = 0.
- State IDLE:
  - ready_o = 1.
  - On valid_i && ready_o: capture x_i into in_q and last_i into last_q; clear pa, pb, w; go to MERGE.
- State MERGE (ready_o = 0, exactly K cycles):
  - Each cycle, if buf[pa] >= in_q[pb]: nb[w] = buf[pa], pa++. Otherwise nb[w] = in_q[pb], pb++.
  - w++ every cycle.
  - On the cycle with w == K-1, commit nb into buf.
  - Next state: OUT if last_q, else IDLE.
  - Pointer reach: pa <= K and pb <= K; no out-of-range element is read before w reaches K.
- State OUT:
  - out_valid_o = 1; y_o = buf; y_o and idx_o stay stable while out_ready_i = 0.
  - On out_valid_o && out_ready_i: clear buf to 0, clear idx buffer and block counter, go to IDLE.
  - ready_o = 0 throughout OUT.
- Timing and latency:
  - Block accepted in cycle t → buf updated at the end of cycle t+K.
  - If that block is last → out_valid_o first high in cycle t+K+1.
  - Sustained throughput: one block per K+1 cycles.
- Outside OUT, y_o still reflects buf, but it is only meaningful while out_valid_o = 1.
- Tie rule: equal values prefer the buffer (earlier data), which keeps the merge stable.
- Zero-initialised buffer: buffer zeros may win over input zeros. Value results are unaffected; this matters only for indices.
- valid_i while ready_o = 0: ignored; upstream must hold the block.
- last_i is sampled only on accept.
- Single-block frame: y_o = x_i[0..K-1].
- Reset mid-MERGE or mid-OUT: immediate return to reset values; the partial frame is discarded.
- Block counter (TOPK_IDX_EN): increments on each accept and wraps modulo 2^IDXWIDTH.

Optional Feature:
- Macro: TOPK_IDX_EN.
- Defined:
  - idx_o port exists.
  - Each input element carries index blk_cnt*DATALENGTH + position, truncated to IDXWIDTH.
  - Indices move through the merge alongside their values; zero-filled buffer entries have idx 0.
- Undefined:
  - No idx_o port, no index storage, no block counter.
  - Value behaviour and timing are identical.

Test Plan:
- Single block: K=8, x_i = 31..0 descending with last_i = 1, accepted at cycle 0 → out_valid_o high at cycle 9; y_o = 31,30,...,24.
- Two-block frame: block A = even values 62..0, then block B = odd values 63..1 with last_i = 1 → y_o = 63,62,...,48 (K=16); ready_o low for exactly K cycles after each accept.
- Backpressure: hold out_ready_i = 0 for 5 cycles in OUT → y_o stable, ready_o = 0, an offered valid_i is not accepted; assert out_ready_i → IDLE next cycle, buffer zeroed, next frame's result is unaffected by the prior frame.
- Valid during merge: hold valid_i = 1 with changing x_i during MERGE → only the block present at the accept cycle is used; the next accept happens K+1 cycles after the first.
- Async reset: assert rst_i mid-MERGE between clock edges → outputs reach reset values immediately; a fresh single-block frame afterwards gives the correct top-K.
- Ties (TOPK_IDX_EN): block 0 all 5s, block 1 all 5s with last_i → y_o all 5; idx_o = 0..K-1, all from block 0.

Source files
------------

// File: rtl/topk_acc_32_if.sv
// Block-in / result-out bundle for topk_acc_32.
// idx_o is present only when TOPK_IDX_EN is defined.
interface topk_acc_32_if #(
  parameter int DATAWIDTH  = 8,
  parameter int DATALENGTH = 32,
  parameter int K          = 16,
  parameter int IDXWIDTH   = 16
);
  logic                                 valid_i;
  logic                                 ready_o;
  logic                                 last_i;
  logic [DATALENGTH-1:0][DATAWIDTH-1:0] x_i;
  logic                                 out_valid_o;
  logic                                 out_ready_i;
  logic [K-1:0][DATAWIDTH-1:0]          y_o;
`ifdef TOPK_IDX_EN
  logic [K-1:0][IDXWIDTH-1:0]           idx_o;

  modport slave (
    input  valid_i, last_i, x_i, out_ready_i,
    output ready_o, out_valid_o, y_o, idx_o
  );
  modport master (
    output valid_i, last_i, x_i, out_ready_i,
    input  ready_o, out_valid_o, y_o, idx_o
  );
`else
  modport slave (
    input  valid_i, last_i, x_i, out_ready_i,
    output ready_o, out_valid_o, y_o
  );
  modport master (
    output valid_i, last_i, x_i, out_ready_i,
    input  ready_o, out_valid_o, y_o
  );
`endif
endinterface

// File: rtl/topk_acc_32.sv
// Streaming top-K accumulator: merges sorted blocks into a running top-K buffer.
// Optional TOPK_IDX_EN carries a source index alongside every value.
//
// state | meaning
// IDLE  | ready for a block; buffer holds the partial frame result
// MERGE | K-cycle two-pointer merge of buffer and captured block
// OUT   | frame result presented until out_ready_i
module topk_acc_32 #(
  parameter int DATAWIDTH  = 8,
  parameter int DATALENGTH = 32,
  parameter int K          = 16,
  parameter int IDXWIDTH   = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  topk_acc_32_if.slave bus
);
  localparam int CW = $clog2(K + 1);
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  if (K < 1 || K > DATALENGTH || IDXWIDTH < 1) begin : g_bad_param
    $error("topk_acc_32: K must lie in 1..DATALENGTH");
  end

  typedef enum logic [1:0] {IDLE, MERGE, OUT} state_t;

  state_t                      state_q, state_d;
  logic [K-1:0][DATAWIDTH-1:0] buf_q, buf_d;
  logic [K-1:0][DATAWIDTH-1:0] nb_q, nb_d;
  logic [K-1:0][DATAWIDTH-1:0] in_q, in_d;
  logic                        last_q, last_d;
  logic [CW-1:0]               pa_q, pa_d, pb_q, pb_d, w_q, w_d;

  logic [DATAWIDTH-1:0] a_v, b_v, pick_v;
  logic                 take_a, accept, merging, commit, release_w;

  // Only the first K input elements can ever reach the result.
  assign a_v     = buf_q[IW'(pa_q)];
  assign b_v     = in_q[IW'(pb_q)];
  assign take_a  = (a_v >= b_v);
  assign pick_v  = take_a ? a_v : b_v;

  assign accept    = (state_q == IDLE) && bus.valid_i;
  assign merging   = (state_q == MERGE);
  assign commit    = merging && (w_q == CW'(K - 1));
  assign release_w = (state_q == OUT) && bus.out_ready_i;

  assign bus.ready_o     = (state_q == IDLE);
  assign bus.out_valid_o = (state_q == OUT);
  assign bus.y_o         = buf_q;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    nb_d    = nb_q;
    in_d    = in_q;
    last_d  = last_q;
    pa_d    = pa_q;
    pb_d    = pb_q;
    w_d     = w_q;
    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          in_d    = bus.x_i[K-1:0];
          last_d  = bus.last_i;
          pa_d    = '0;
          pb_d    = '0;
          w_d     = '0;
          state_d = MERGE;
        end
      end
      MERGE: begin
        nb_d[IW'(w_q)] = pick_v;
        if (take_a) pa_d = pa_q + CW'(1);
        else        pb_d = pb_q + CW'(1);
        w_d = w_q + CW'(1);
        if (commit) begin
          buf_d          = nb_q;
          buf_d[IW'(w_q)] = pick_v;
          state_d        = last_q ? OUT : IDLE;
        end
      end
      OUT: begin
        if (bus.out_ready_i) begin
          buf_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      buf_q   <= '0;
      nb_q    <= '0;
      in_q    <= '0;
      last_q  <= 1'b0;
      pa_q    <= '0;
      pb_q    <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      nb_q    <= nb_d;
      in_q    <= in_d;
      last_q  <= last_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      w_q     <= w_d;
    end
  end

`ifdef TOPK_IDX_EN
  logic [K-1:0][IDXWIDTH-1:0] ibuf_q, ibuf_d, nidx_q, nidx_d, iin_q, iin_d;
  logic [IDXWIDTH-1:0]        blk_cnt_q, blk_cnt_d, pick_idx;

  always_comb begin
    ibuf_d    = ibuf_q;
    nidx_d    = nidx_q;
    iin_d     = iin_q;
    blk_cnt_d = blk_cnt_q;
    pick_idx  = take_a ? ibuf_q[IW'(pa_q)] : iin_q[IW'(pb_q)];
    if (accept) begin
      for (int p = 0; p < K; p++) begin
        iin_d[p] = blk_cnt_q * IDXWIDTH'(DATALENGTH) + IDXWIDTH'(p);
      end
      blk_cnt_d = blk_cnt_q + IDXWIDTH'(1);
    end
    if (merging) nidx_d[IW'(w_q)] = pick_idx;
    if (commit) begin
      ibuf_d          = nidx_q;
      ibuf_d[IW'(w_q)] = pick_idx;
    end
    if (release_w) begin
      ibuf_d    = '0;
      blk_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ibuf_q    <= '0;
      nidx_q    <= '0;
      iin_q     <= '0;
      blk_cnt_q <= '0;
    end else begin
      ibuf_q    <= ibuf_d;
      nidx_q    <= nidx_d;
      iin_q     <= iin_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign bus.idx_o = ibuf_q;
`endif
endmodule

// File: tb/tb_topk_acc_32.sv
// Directed bench for topk_acc_32: single/two-block frames, backpressure,
// valid held during merge, async reset mid-merge and (TOPK_IDX_EN) tie indices.
module tb_topk_acc_32;
  localparam int DW   = 8;
  localparam int DL   = 32;
  localparam int K    = 16;
  localparam int IDXW = 16;

  typedef logic [DL-1:0][DW-1:0] blk_t;
  typedef logic [K-1:0][DW-1:0]  res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  topk_acc_32_if #(.DATAWIDTH(DW), .DATALENGTH(DL), .K(K), .IDXWIDTH(IDXW)) bus_if ();

  topk_acc_32 #(.DATAWIDTH(DW), .DATALENGTH(DL), .K(K), .IDXWIDTH(IDXW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic blk_t ramp_blk(input int start, input int step);
    blk_t b;
    for (int p = 0; p < DL; p++) b[p] = DW'(start - step * p);
    return b;
  endfunction

  function automatic res_t ramp_res(input int start, input int step);
    res_t r;
    for (int i = 0; i < K; i++) r[i] = DW'(start - step * i);
    return r;
  endfunction

  // Present a block until the accepting edge; returns sampling just after it.
  task automatic offer(input blk_t blk, input logic last);
    int n;
    n = 0;
    bus_if.x_i     = blk;
    bus_if.last_i  = last;
    bus_if.valid_i = 1'b1;
    while (!bus_if.ready_o && n < 200) begin
      tick();
      n++;
    end
    check("ready_before_accept", bus_if.ready_o, 1);
    tick();
    bus_if.valid_i = 1'b0;
    bus_if.last_i  = 1'b0;
  endtask

  // Called right after the accepting edge of a last block.
  task automatic wait_result(input string tag);
    int n;
    int rdy_hi;
    n = 0;
    rdy_hi = 0;
    while (!bus_if.out_valid_o && n < 200) begin
      if (bus_if.ready_o) rdy_hi++;
      tick();
      n++;
    end
    check({tag, "_latency"}, n + 1, K + 1);
    check({tag, "_ready_low"}, rdy_hi, 0);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!bus_if.ready_o && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_busy_cycles"}, n, K);
  endtask

  task automatic release_result(input string tag);
    bus_if.out_ready_i = 1'b1;
    tick();
    bus_if.out_ready_i = 1'b0;
    check({tag, "_rel_valid"}, bus_if.out_valid_o, 0);
    check({tag, "_rel_ready"}, bus_if.ready_o, 1);
    check({tag, "_rel_y_zero"}, bus_if.y_o, 0);
  endtask

  localparam int MIX_EXP [K] = '{64, 62, 60, 58, 56, 54, 52, 50, 50, 49, 48, 48, 47, 46, 46, 45};

  initial begin
    res_t exp_r;
    int   n;

    bus_if.valid_i     = 1'b0;
    bus_if.last_i      = 1'b0;
    bus_if.x_i         = '0;
    bus_if.out_ready_i = 1'b0;

    // reset values while reset is held
    #2;
    check("rst_ready", bus_if.ready_o, 1);
    check("rst_out_valid", bus_if.out_valid_o, 0);
    check("rst_y", bus_if.y_o, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // single-block frame
    offer(ramp_blk(31, 1), 1'b1);
    wait_result("single");
    check("single_y", bus_if.y_o, ramp_res(31, 1));
    release_result("single");

    // two-block frame: evens then odds
    offer(ramp_blk(62, 2), 1'b0);
    wait_ready("two_a");
    offer(ramp_blk(63, 2), 1'b1);
    wait_result("two");
    check("two_y", bus_if.y_o, ramp_res(63, 1));

    // backpressure with a competing block offered
    bus_if.x_i     = ramp_blk(200, 0);
    bus_if.last_i  = 1'b0;
    bus_if.valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_y_stable", bus_if.y_o, ramp_res(63, 1));
      check("bp_ready_low", bus_if.ready_o, 0);
      check("bp_valid_high", bus_if.out_valid_o, 1);
      tick();
    end
    bus_if.valid_i = 1'b0;
    release_result("bp");
    offer(ramp_blk(47, 1), 1'b1);
    wait_result("after_bp");
    check("after_bp_y", bus_if.y_o, ramp_res(47, 1));
    release_result("after_bp");

    // valid held high with changing data during merge
    offer(ramp_blk(50, 1), 1'b0);
    n = 0;
    while (!bus_if.ready_o && n < 200) begin
      bus_if.x_i     = ramp_blk(255 - n, 0);
      bus_if.last_i  = 1'b1;
      bus_if.valid_i = 1'b1;
      tick();
      n++;
    end
    check("hold_next_accept", n, K);
    bus_if.x_i    = ramp_blk(64, 2);
    bus_if.last_i = 1'b1;
    tick();
    bus_if.valid_i = 1'b0;
    bus_if.last_i  = 1'b0;
    wait_result("hold");
    for (int i = 0; i < K; i++) exp_r[i] = DW'(MIX_EXP[i]);
    check("hold_y", bus_if.y_o, exp_r);
    release_result("hold");

    // async reset in the middle of the second block's merge
    offer(ramp_blk(70, 1), 1'b0);
    wait_ready("rst_a");
    offer(ramp_blk(80, 1), 1'b1);
    tick();
    tick();
    check("pre_rst_y", bus_if.y_o, ramp_res(70, 1));
    check("pre_rst_ready", bus_if.ready_o, 0);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_ready", bus_if.ready_o, 1);
    check("async_rst_valid", bus_if.out_valid_o, 0);
    check("async_rst_y", bus_if.y_o, 0);
    tick();
    rst = 1'b0;
    tick();
    offer(ramp_blk(90, 1), 1'b1);
    wait_result("post_rst");
    check("post_rst_y", bus_if.y_o, ramp_res(90, 1));
    release_result("post_rst");

`ifdef TOPK_IDX_EN
    // equal values: buffer wins, so indices all come from block 0
    offer(ramp_blk(5, 0), 1'b0);
    wait_ready("tie_a");
    offer(ramp_blk(5, 0), 1'b1);
    wait_result("tie");
    check("tie_y", bus_if.y_o, ramp_res(5, 0));
    begin
      logic [K-1:0][IDXW-1:0] exp_idx;
      for (int i = 0; i < K; i++) exp_idx[i] = IDXW'(i);
      check("tie_idx", bus_if.idx_o, exp_idx);
    end
    release_result("tie");
    check("tie_idx_cleared", bus_if.idx_o, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
